// File: rtl/timer_sched_pkg.sv
// Shared state encoding, timer register map and scheduling constants for timer_sched.
package timer_sched_pkg;

   typedef enum logic [3:0] {
      ST_INIT     = 4'd0,
      ST_INIT2    = 4'd1,
      ST_IDLE     = 4'd2,
      ST_WR_PL    = 4'd3,
      ST_WR_PH    = 4'd4,
      ST_WR_CTRL  = 4'd5,
      ST_WAIT_IRQ = 4'd6,
      ST_CLR_ST   = 4'd7,
      ST_DONE     = 4'd8
   } state_t;

   localparam int TMR_STATUS  = 0;
   localparam int TMR_CONTROL = 1;
   localparam int TMR_PERIODL = 2;
   localparam int TMR_PERIODH = 3;

   localparam int CTRL_ITO_BIT   = 0;
   localparam int CTRL_CONT_BIT  = 1;
   localparam int CTRL_START_BIT = 2;
   localparam int CTRL_STOP_BIT  = 3;

   localparam logic [15:0] CTRL_START_ITO = 16'((1 << CTRL_START_BIT) | (1 << CTRL_ITO_BIT));
   localparam logic [15:0] CTRL_STOP      = 16'(1 << CTRL_STOP_BIT);

   // Ack-to-done latency is delay + SCHED_OVERHEAD: PL/PH/CTRL writes (bus is one cycle behind state),
   // timer arm, irq sample into CLR_ST, DONE, and the registered done pulse.
   localparam int SCHED_OVERHEAD = 7;

   function automatic logic [2:0] onehot_idx(input logic [7:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < 8; i++) begin
         idx = idx | (3'(i) & {3{oh[i]}});
      end
      return idx;
   endfunction

endpackage

// File: rtl/timer_sched_arbiter.sv
// One-hot request arbiter. Round-robin from i_ptr by default;
// TIMER_SCHED_FIXED_PRIO_EN selects fixed lowest-index priority and drops the pointer.
module timer_sched_arbiter
   import timer_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] i_req,
`ifdef TIMER_SCHED_FIXED_PRIO_EN
`else
   input  logic [PW-1:0]   i_ptr,
`endif
   output logic [NREQ-1:0] o_grant,
   output logic            o_valid
);

   logic [NREQ-1:0] w_grant;
   logic            w_found;
`ifdef TIMER_SCHED_FIXED_PRIO_EN
`else
   logic [PW-1:0]   w_j;
`endif

   // First requester found in search order wins.
   always_comb begin
      w_grant = '0;
      w_found = 1'b0;
`ifdef TIMER_SCHED_FIXED_PRIO_EN
      for (int k = 0; k < NREQ; k++) begin
         w_grant[k] = i_req[k] & ~w_found;
         w_found    = w_found | i_req[k];
      end
`else
      w_j = '0;
      for (int k = 0; k < NREQ; k++) begin
         w_j          = PW'((int'(i_ptr) + k) % NREQ);
         w_grant[w_j] = i_req[w_j] & ~w_found;
         w_found      = w_found | i_req[w_j];
      end
`endif
   end

   assign o_grant = w_grant;
   assign o_valid = |i_req;

endmodule

// File: rtl/timer_sched.sv
// Shares one interval timer between NREQ one-shot delay requesters.
// Build option: TIMER_SCHED_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module timer_sched
   import timer_sched_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int DW   = 16,
   parameter int AW   = 3
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*32-1:0] req_delay,
   output logic [NREQ-1:0]  ack,
   output logic [NREQ-1:0]  done,
   output logic             busy,
   output logic [AW-1:0]    avm_address,
   output logic             avm_chipselect,
   output logic             avm_write_n,
   output logic [DW-1:0]    avm_writedata,
   input  logic             timer_irq
);

   localparam int PW = $clog2(NREQ);

   state_t          r_state, w_next;
   logic [NREQ-1:0] r_ack, r_done, r_win, w_grant;
   logic            r_busy, w_valid, w_take;
   logic [31:0]     r_period, w_win_delay;
   logic            r_cs, r_wn, w_wr;
   logic [AW-1:0]   r_addr, w_addr;
   logic [DW-1:0]   r_wdata, w_data;

`ifdef TIMER_SCHED_FIXED_PRIO_EN
`else
   logic [PW-1:0]   r_ptr;

   // Round-robin pointer holds the index just after the latest winner.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_ptr <= '0;
      else if (w_take) r_ptr <= PW'((int'(onehot_idx(8'(w_grant))) + 1) % NREQ);
      else r_ptr <= r_ptr;
   end
`endif

   timer_sched_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
      .i_req   (req),
`ifdef TIMER_SCHED_FIXED_PRIO_EN
`else
      .i_ptr   (r_ptr),
`endif
      .o_grant (w_grant),
      .o_valid (w_valid)
   );

   // The done cycle still belongs to the finishing job, so no grant is made in it.
   assign w_take = (r_state == ST_IDLE) && w_valid && (r_done == '0);

   always_comb begin
      w_win_delay = 32'd0;
      for (int i = 0; i < NREQ; i++) begin
         w_win_delay = w_win_delay | (req_delay[32*i +: 32] & {32{w_grant[i]}});
      end
   end

   // Next state and the register write owned by the current state.
   always_comb begin
      w_next = r_state;
      w_wr   = 1'b0;
      w_addr = '0;
      w_data = '0;
      case (r_state)
         ST_INIT: begin
            w_wr = 1'b1; w_addr = AW'(TMR_CONTROL); w_data = DW'(CTRL_STOP); w_next = ST_INIT2;
         end
         ST_INIT2: begin
            w_wr = 1'b1; w_addr = AW'(TMR_STATUS); w_data = '0; w_next = ST_IDLE;
         end
         ST_IDLE: begin
            if (w_take) w_next = (w_win_delay <= 32'd1) ? ST_DONE : ST_WR_PL;
            else w_next = ST_IDLE;
         end
         ST_WR_PL: begin
            w_wr = 1'b1; w_addr = AW'(TMR_PERIODL); w_data = DW'(r_period[15:0]); w_next = ST_WR_PH;
         end
         ST_WR_PH: begin
            w_wr = 1'b1; w_addr = AW'(TMR_PERIODH); w_data = DW'(r_period[31:16]); w_next = ST_WR_CTRL;
         end
         ST_WR_CTRL: begin
            w_wr = 1'b1; w_addr = AW'(TMR_CONTROL); w_data = DW'(CTRL_START_ITO); w_next = ST_WAIT_IRQ;
         end
         ST_WAIT_IRQ: begin
            if (timer_irq) w_next = ST_CLR_ST;
            else w_next = ST_WAIT_IRQ;
         end
         ST_CLR_ST: begin
            w_wr = 1'b1; w_addr = AW'(TMR_STATUS); w_data = '0; w_next = ST_DONE;
         end
         ST_DONE:  w_next = ST_IDLE;
         default:  w_next = ST_INIT;
      endcase
   end

   // State, job latch and registered bus/handshake outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_INIT;
         r_ack    <= '0;
         r_done   <= '0;
         r_win    <= '0;
         r_busy   <= 1'b0;
         r_period <= 32'd0;
         r_cs     <= 1'b0;
         r_wn     <= 1'b1;
         r_addr   <= '0;
         r_wdata  <= '0;
      end else begin
         r_state <= w_next;
         r_cs    <= w_wr;
         r_wn    <= ~w_wr;
         r_addr  <= w_addr;
         r_wdata <= w_data;
         r_ack   <= w_take ? w_grant : '0;
         r_done  <= (r_state == ST_DONE) ? r_win : '0;
         r_busy  <= w_take | (r_busy & (r_state != ST_IDLE));
         if (w_take) begin
            r_win    <= w_grant;
            r_period <= w_win_delay - 32'd1;
         end else begin
            r_win    <= r_win;
            r_period <= r_period;
         end
      end
   end

   assign ack            = r_ack;
   assign done           = r_done;
   assign busy           = r_busy;
   assign avm_address    = r_addr;
   assign avm_chipselect = r_cs;
   assign avm_write_n    = r_wn;
   assign avm_writedata  = r_wdata;

endmodule

// File: tb/tb_timer_sched.sv
// Scoreboard bench for timer_sched with a behavioural one-shot interval timer on the bus.
module tb_timer_sched;

   localparam int NREQ = 4;

   logic               clk = 1'b0;
   logic               reset_n = 1'b0;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ*32-1:0] req_delay = '0;
   logic [NREQ-1:0]    ack, done;
   logic               busy, avm_chipselect, avm_write_n, timer_irq;
   logic [2:0]         avm_address;
   logic [15:0]        avm_writedata;

   timer_sched #(.NREQ(NREQ), .DW(16), .AW(3)) dut (
      .clk(clk), .reset_n(reset_n), .req(req), .req_delay(req_delay),
      .ack(ack), .done(done), .busy(busy),
      .avm_address(avm_address), .avm_chipselect(avm_chipselect),
      .avm_write_n(avm_write_n), .avm_writedata(avm_writedata),
      .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural timer: counts period..0 then sets timeout; one-shot; not reset by reset_n.
   logic [15:0] t_pl = 16'd0, t_ph = 16'd0;
   logic [31:0] t_cnt = 32'd0;
   logic        t_run = 1'b0, t_to = 1'b0, t_ito = 1'b0, irq_force = 1'b0;
   always @(posedge clk) begin
      if (avm_chipselect && !avm_write_n) begin
         case (avm_address)
            3'd0: t_to <= 1'b0;
            3'd1: begin
               t_ito <= avm_writedata[0];
               if (avm_writedata[3]) t_run <= 1'b0;
               else if (avm_writedata[2]) begin t_run <= 1'b1; t_cnt <= {t_ph, t_pl}; end
            end
            3'd2: t_pl <= avm_writedata;
            3'd3: t_ph <= avm_writedata;
            default: ;
         endcase
      end else if (t_run) begin
         if (t_cnt == 32'd0) begin t_to <= 1'b1; t_run <= 1'b0; end
         else t_cnt <= t_cnt - 32'd1;
      end
   end
   assign timer_irq = (t_to & t_ito) | irq_force;

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
      end
   endtask

   logic [18:0] exp_wr[$];
   int          exp_ack[$];
   int          exp_done[$];
   int          exp_lat[$];

   int ack_cnt = 0, done_cnt = 0, ack_cyc = 0, last_lat = 0;
   logic in_flight = 1'b0;

   // Monitor: pops expectations whenever the DUT presents a write, ack or done.
   initial begin
      int i, l;
      logic [18:0] w;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            in_flight = 1'b0;
         end else begin
            chk("busy", busy, in_flight | (ack != '0));
            chk("write_n_vs_cs", avm_write_n, !avm_chipselect);
            if (avm_chipselect) begin
               if (exp_wr.size() == 0) chk("unexpected_write", {avm_address, avm_writedata}, 19'h0);
               else begin w = exp_wr.pop_front(); chk("bus_write", {avm_address, avm_writedata}, w); end
            end
            if (ack != '0) begin
               if (in_flight) chk("ack_while_busy", 1, 0);
               if (exp_ack.size() == 0) chk("unexpected_ack", ack, 0);
               else begin i = exp_ack.pop_front(); chk("ack_onehot", ack, 4'b1 << i); end
               ack_cyc = cyc; in_flight = 1'b1; ack_cnt++;
            end
            if (done != '0) begin
               if (exp_done.size() == 0) chk("unexpected_done", done, 0);
               else begin
                  i = exp_done.pop_front(); l = exp_lat.pop_front();
                  chk("done_onehot", done, 4'b1 << i);
                  chk("ack_to_done", cyc - ack_cyc, l);
               end
               last_lat = cyc - ack_cyc; in_flight = 1'b0; done_cnt++;
            end
         end
      end
   end

   task automatic push_job(input int idx, input logic [15:0] pl, input logic [15:0] ph,
                           input int lat, input bit short_job, input bit with_done);
      if (!short_job) begin
         exp_wr.push_back({3'd2, pl});
         exp_wr.push_back({3'd3, ph});
         exp_wr.push_back({3'd1, 16'h0005});
         if (with_done) exp_wr.push_back({3'd0, 16'h0000});
      end
      exp_ack.push_back(idx);
      if (with_done) begin exp_done.push_back(idx); exp_lat.push_back(lat); end
   endtask

   task automatic wait_acks(input int target, input int budget, input string name);
      int n = 0;
      while (ack_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
      chk(name, ack_cnt >= target, 1);
   endtask

   task automatic wait_dones(input int target, input int budget, input string name);
      int n = 0;
      while (done_cnt < target && n < budget) begin @(negedge clk); #1; n++; end
      chk(name, done_cnt >= target, 1);
   endtask

   task automatic run_single(input int idx, input logic [31:0] dly, input logic [15:0] pl,
                             input logic [15:0] ph, input int lat, input bit short_job);
      int a0, d0;
      a0 = ack_cnt; d0 = done_cnt;
      push_job(idx, pl, ph, lat, short_job, 1'b1);
      req_delay[32*idx +: 32] = dly;
      req[idx] = 1'b1;
      wait_acks(a0 + 1, 20, "ack_timeout");
      req[idx] = 1'b0;
      req_delay[32*idx +: 32] = 32'hDEAD_BEEF;
      wait_dones(d0 + 1, lat + 40, "done_timeout");
      repeat (3) @(negedge clk);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_ack"}, ack, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_cs"}, avm_chipselect, 0);
      chk({tag, "_write_n"}, avm_write_n, 1);
      chk({tag, "_addr"}, avm_address, 0);
      chk({tag, "_wdata"}, avm_writedata, 0);
   endtask

   initial begin
      int a0, d0, lat_a;
      repeat (3) @(negedge clk);
      #1 chk_reset_outputs("rst");
      exp_wr.push_back({3'd1, 16'h0008});
      exp_wr.push_back({3'd0, 16'h0000});
      @(negedge clk); reset_n = 1'b1;
      repeat (6) @(negedge clk);
      chk("init_writes_seen", exp_wr.size(), 0);
      chk("no_ack_after_init", ack_cnt, 0);

      // All four requesters held with delay 20 (period 0x13).
      a0 = ack_cnt; d0 = done_cnt;
      for (int k = 0; k < NREQ; k++) req_delay[32*k +: 32] = 32'd20;
`ifdef TIMER_SCHED_FIXED_PRIO_EN
      for (int k = 0; k < 5; k++) push_job(0, 16'h0013, 16'h0000, 27, 1'b0, 1'b1);
`else
      push_job(0, 16'h0013, 16'h0000, 27, 1'b0, 1'b1);
      push_job(1, 16'h0013, 16'h0000, 27, 1'b0, 1'b1);
      push_job(2, 16'h0013, 16'h0000, 27, 1'b0, 1'b1);
      push_job(3, 16'h0013, 16'h0000, 27, 1'b0, 1'b1);
      push_job(0, 16'h0013, 16'h0000, 27, 1'b0, 1'b1);
`endif
      req = 4'hF;
      wait_acks(a0 + 5, 400, "rr_ack_timeout");
      req = 4'h0;
      wait_dones(d0 + 5, 100, "rr_done_timeout");
      repeat (3) @(negedge clk);

      run_single(0, 32'd10, 16'h0009, 16'h0000, 17, 1'b0);
      lat_a = last_lat;
      run_single(0, 32'h0001_0000, 16'hFFFF, 16'h0000, 65543, 1'b0);
      chk("latency_delta", last_lat - lat_a, 65526);

      run_single(2, 32'd0, 16'h0000, 16'h0000, 1, 1'b1);
      run_single(3, 32'd1, 16'h0000, 16'h0000, 1, 1'b1);

      // A spurious irq in IDLE must cause no activity.
      a0 = ack_cnt; d0 = done_cnt;
      irq_force = 1'b1;
      repeat (10) @(negedge clk);
      irq_force = 1'b0;
      repeat (2) @(negedge clk);
      chk("irq_idle_no_ack", ack_cnt, a0);
      chk("irq_idle_no_done", done_cnt, d0);
      run_single(1, 32'd10, 16'h0009, 16'h0000, 17, 1'b0);

      // Reset while waiting on the timer: no done for the aborted job.
      a0 = ack_cnt; d0 = done_cnt;
      push_job(1, 16'h0063, 16'h0000, 0, 1'b0, 1'b0);
      req_delay[32*1 +: 32] = 32'd100;
      req[1] = 1'b1;
      wait_acks(a0 + 1, 20, "abort_ack_timeout");
      req[1] = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_writes_seen", exp_wr.size(), 0);
      #2 reset_n = 1'b0;
      #1 chk_reset_outputs("midrst");
      exp_wr.push_back({3'd1, 16'h0008});
      exp_wr.push_back({3'd0, 16'h0000});
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (200) @(negedge clk);
      chk("abort_no_done", done_cnt, d0);
      chk("reinit_writes_seen", exp_wr.size(), 0);

      run_single(2, 32'd10, 16'h0009, 16'h0000, 17, 1'b0);

      chk("wr_queue_empty", exp_wr.size(), 0);
      chk("ack_queue_empty", exp_ack.size(), 0);
      chk("done_queue_empty", exp_done.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
